// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life engine: default geometry,
// FSM state encoding and the birth/survival rule.
package life_pkg;

    localparam int DEF_GRID_W     = 16;
    localparam int DEF_GRID_H     = 16;
    localparam int DEF_CELL_SHIFT = 4;
    localparam int DEF_GEN_FRAMES = 30;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_SWAP    = 2'd2
    } life_state_t;

    // Conway rule: birth on 3, survival on 2 or 3.
    function automatic logic next_state(input logic alive, input logic [3:0] n);
        return (n == 4'd3) | (alive & (n == 4'd2));
    endfunction

    // Row contents of the power-on glider, bit i = column i.
    function automatic logic [31:0] glider_row(input int y);
        case (y)
            0:       return 32'h0000_0002;
            1:       return 32'h0000_0004;
            2:       return 32'h0000_0007;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/life_neigh_count.sv
// Combinational 3x3 window evaluator: neighbour sum and next cell state.
// Window bit 4 is the centre cell; bits 0..2 are the row above (x-1,x,x+1),
// 3..5 the centre row, 6..8 the row below.
module life_neigh_count
    import life_pkg::*;
(
    input  logic [8:0] i_window,
    output logic [3:0] o_n,
    output logic       o_next
);

    assign o_n = {3'b000, i_window[0]} + {3'b000, i_window[1]} + {3'b000, i_window[2]}
               + {3'b000, i_window[3]}                         + {3'b000, i_window[5]}
               + {3'b000, i_window[6]} + {3'b000, i_window[7]} + {3'b000, i_window[8]};

    assign o_next = next_state(i_window[4], o_n);

endmodule

// File: rtl/life_engine.sv
// Game-of-Life generation engine. Two grid banks: the display always reads
// the front bank while the next generation is built in the back bank one
// cell per clock; a single SWAP cycle then flips the bank select.
module life_engine
    import life_pkg::*;
#(
    parameter int GRID_W     = DEF_GRID_W,
    parameter int GRID_H     = DEF_GRID_H,
    parameter int CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int GEN_FRAMES = DEF_GEN_FRAMES
) (
    input  logic                      dclk,
    input  logic                      clr,
    input  logic                      frame_tick,
    input  logic                      pause,
    input  logic                      seed_we,
    input  logic [$clog2(GRID_H)-1:0] seed_row,
    input  logic [GRID_W-1:0]         seed_data,
    input  logic [9:0]                VGAx,
    input  logic [9:0]                VGAy,
    output logic                      cell_on,
    output logic                      busy,
    output logic [15:0]               generation
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int IW = XW + YW;
    localparam int FW = (GEN_FRAMES > 1) ? $clog2(GEN_FRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(GRID_W * GRID_H - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(GEN_FRAMES - 1);

    life_state_t       r_state;
    logic [GRID_W-1:0] r_bank [2][GRID_H];
    logic              r_sel;
    logic [IW-1:0]     r_idx;
    logic [FW-1:0]     r_frame_cnt;
    logic [15:0]       r_gen;
    logic              r_busy;
    logic              r_cell_on;

    logic              w_back_sel;
    logic [XW-1:0]     w_x, w_xm, w_xp;
    logic [YW-1:0]     w_y, w_ym, w_yp;
    logic [GRID_W-1:0] w_row_m, w_row_c, w_row_p;
    logic [8:0]        w_window;
    logic [3:0]        w_unused_n;
    logic              w_next;
    logic [9:0]        w_cx, w_cy;
    logic              w_in_grid;
    logic              w_front_pix;

    assign w_back_sel = ~r_sel;

    // Power-of-two grid dimensions make toroidal wrap a plain modular add.
    assign w_x  = r_idx[XW-1:0];
    assign w_y  = r_idx[IW-1:XW];
    assign w_xm = w_x - XW'(1);
    assign w_xp = w_x + XW'(1);
    assign w_ym = w_y - YW'(1);
    assign w_yp = w_y + YW'(1);

    assign w_row_m = r_bank[r_sel][w_ym];
    assign w_row_c = r_bank[r_sel][w_y];
    assign w_row_p = r_bank[r_sel][w_yp];

    assign w_window = {w_row_p[w_xp], w_row_p[w_x], w_row_p[w_xm],
                       w_row_c[w_xp], w_row_c[w_x], w_row_c[w_xm],
                       w_row_m[w_xp], w_row_m[w_x], w_row_m[w_xm]};

    // The raw neighbour sum is exposed by the counter but only the rule
    // result is stored.
    life_neigh_count u_neigh (
        .i_window (w_window),
        .o_n      (w_unused_n),
        .o_next   (w_next)
    );

    // Pixel to cell mapping; anything right of / below the grid is dark.
    assign w_cx        = VGAx >> CELL_SHIFT;
    assign w_cy        = VGAy >> CELL_SHIFT;
    assign w_in_grid   = (w_cx < 10'(GRID_W)) && (w_cy < 10'(GRID_H));
    assign w_front_pix = r_bank[r_sel][w_cy[YW-1:0]][w_cx[XW-1:0]];

    // Generation FSM: frame pacing, seeding, per-cell compute and bank swap.
    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_WAIT;
            r_sel       <= 1'b0;
            r_idx       <= {IW{1'b0}};
            r_frame_cnt <= {FW{1'b0}};
            r_gen       <= 16'd0;
            r_busy      <= 1'b0;
            for (int i = 0; i < GRID_H; i++) begin
                r_bank[0][i] <= GRID_W'(glider_row(i));
                r_bank[1][i] <= {GRID_W{1'b0}};
            end
        end else begin
            case (r_state)
                ST_WAIT: begin
                    // Seed lands on the same edge as a triggering tick, so
                    // the first compute cycle already sees it.
                    if (seed_we) begin
                        r_bank[r_sel][seed_row] <= seed_data;
                    end
                    if (frame_tick && !pause) begin
                        if (r_frame_cnt == FRAME_LAST) begin
                            r_frame_cnt <= {FW{1'b0}};
                            r_idx       <= {IW{1'b0}};
                            r_state     <= ST_COMPUTE;
                            r_busy      <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FW'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_bank[w_back_sel][w_y][w_x] <= w_next;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_SWAP;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_SWAP: begin
                    r_sel   <= w_back_sel;
                    r_gen   <= r_gen + 16'd1;
                    r_busy  <= 1'b0;
                    r_state <= ST_WAIT;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    // Registered display lookup from the front bank.
    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            r_cell_on <= 1'b0;
        end else begin
            r_cell_on <= w_in_grid & w_front_pix;
        end
    end

    assign cell_on    = r_cell_on;
    assign busy       = r_busy;
    assign generation = r_gen;

endmodule
